dmem_ctrl: RTL and testbench

- Multi-cycle data-memory controller between the pipeline Memory stage and the data RAM.
- Owns a word-addressed RAM and a parameterised read latency.
- Raises a stall while a load is outstanding, so the Memory stage and every stage behind it freeze until the data returns.
- Stores are posted and complete in one cycle. Misaligned accesses are rejected and flagged.

---
 rtl/dmem_ctrl.sv | 102 ++++++++++
 tb/tb_dmem_ctrl.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_ctrl.sv
// Multi-cycle data-memory controller: word RAM with READ_LAT-cycle loads (stalling the pipeline)
// and single-cycle posted stores; misaligned requests are rejected with a one-cycle misalign pulse.
module dmem_ctrl #(
   parameter int ADDR_W   = 6,
   parameter int READ_LAT = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_read,
   input  logic        req_write,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        rdata_valid,
   output logic        stall,
   output logic        misalign
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t            state, state_nxt;
   logic [3:0]        cnt, cnt_nxt;
   logic [31:0]       rdata_q, rdata_nxt;
   logic              mem_we;
   logic [31:0]       mem [2**ADDR_W];
   logic [ADDR_W-1:0] idx;
   logic              aligned;
   logic              unused_addr_bits;

   assign idx              = addr[ADDR_W+1:2];
   assign aligned          = (addr[1:0] == 2'b00);
   assign unused_addr_bits = ^addr[31:ADDR_W+2];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         rdata_q <= '0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         rdata_q <= rdata_nxt;
      end
   end

   // RAM contents survive reset; mem_we is already gated by reset.
   always_ff @(posedge clk) begin
      if (mem_we) mem[idx] <= wdata;
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      rdata_nxt   = rdata_q;
      stall       = 1'b0;
      rdata_valid = 1'b0;
      misalign    = 1'b0;
      mem_we      = 1'b0;
      rdata       = rdata_q;
      case (state)
         IDLE: begin
            if (req_write) begin
               if (aligned) mem_we   = 1'b1;
               else         misalign = 1'b1;
            end else if (req_read) begin
               if (aligned) begin
                  stall     = 1'b1;
                  cnt_nxt   = 4'(READ_LAT - 1);
                  state_nxt = BUSY;
               end else begin
                  misalign    = 1'b1;
                  rdata_valid = 1'b1;
                  rdata       = '0;
               end
            end
         end
         BUSY: begin
            stall = 1'b1;
            if (cnt != 4'd0) begin
               cnt_nxt = cnt - 4'd1;
            end else begin
               rdata_nxt = mem[idx];
               state_nxt = DONE;
            end
         end
         DONE: begin
            rdata_valid = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      // Outputs must drop the instant reset asserts, even with a request still held.
      if (reset) begin
         stall       = 1'b0;
         rdata_valid = 1'b0;
         misalign    = 1'b0;
         mem_we      = 1'b0;
         rdata       = rdata_q;
      end
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: default build plus a READ_LAT=1 build.
module tb_dmem_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req_read = 1'b0, req_write = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic [31:0] rdata;
   logic        rdata_valid, stall, misalign;

   logic        r1_read = 1'b0, r1_write = 1'b0;
   logic [31:0] r1_addr = '0, r1_wdata = '0;
   logic [31:0] r1_rdata;
   logic        r1_valid, r1_stall, r1_misalign;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q[$];
   logic [31:0] exp1_q[$];

   always #5 clk = ~clk;

   dmem_ctrl #(.ADDR_W(6), .READ_LAT(2)) dut (
      .clk(clk), .reset(reset), .req_read(req_read), .req_write(req_write),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
      .stall(stall), .misalign(misalign));

   dmem_ctrl #(.ADDR_W(6), .READ_LAT(1)) dut1 (
      .clk(clk), .reset(reset), .req_read(r1_read), .req_write(r1_write),
      .addr(r1_addr), .wdata(r1_wdata), .rdata(r1_rdata), .rdata_valid(r1_valid),
      .stall(r1_stall), .misalign(r1_misalign));

   // Scoreboard: every rdata_valid pulse must match the oldest pushed expectation.
   always @(negedge clk) begin
      if (!reset && rdata_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL sb_unexpected: rdata_valid with rdata=%h, no load pending", rdata);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (rdata !== e) begin
               failures++;
               $display("FAIL sb_rdata: got %h expected %h", rdata, e);
            end
         end
      end
      if (!reset && r1_valid) begin
         checks++;
         if (exp1_q.size() == 0) begin
            failures++;
            $display("FAIL sb1_unexpected: rdata_valid with rdata=%h", r1_rdata);
         end else begin
            logic [31:0] e;
            e = exp1_q.pop_front();
            if (r1_rdata !== e) begin
               failures++;
               $display("FAIL sb1_rdata: got %h expected %h", r1_rdata, e);
            end
         end
      end
   end

   task automatic go_idle();
      @(posedge clk); #1;
      req_read = 1'b0; req_write = 1'b0;
   endtask

   task automatic do_store(input logic [31:0] a, input logic [31:0] d);
      @(posedge clk); #1;
      req_read = 1'b0; req_write = 1'b1; addr = a; wdata = d;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || misalign !== 1'b0) begin
         failures++;
         $display("FAIL store_%h: stall=%b misalign=%b expected 0 0", a, stall, misalign);
      end
   endtask

   // Issues a load, counts the stall burst and confirms the DONE cycle; data goes via scoreboard.
   task automatic do_load(input logic [31:0] a, input logic [31:0] e, input int exp_stall);
      int  n;
      bit  done;
      n = 0; done = 0;
      @(posedge clk); #1;
      req_write = 1'b0; req_read = 1'b1; addr = a;
      exp_q.push_back(e);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (stall) n++;
         else       done = 1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL load_timeout_%h: stall still high after 40 cycles", a);
      end
      checks++;
      if (n != exp_stall) begin
         failures++;
         $display("FAIL load_stall_len_%h: got %0d cycles expected %0d", a, n, exp_stall);
      end
      checks++;
      if (rdata_valid !== 1'b1) begin
         failures++;
         $display("FAIL load_valid_%h: rdata_valid=%b expected 1", a, rdata_valid);
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rdata_valid !== 1'b0 || misalign !== 1'b0 || rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs: stall=%b valid=%b misalign=%b rdata=%h expected 0 0 0 0",
                  stall, rdata_valid, misalign, rdata);
      end
      checks++;
      if (r1_stall !== 1'b0 || r1_valid !== 1'b0 || r1_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_outputs_lat1: stall=%b valid=%b rdata=%h expected 0 0 0",
                  r1_stall, r1_valid, r1_rdata);
      end
      @(posedge clk); #1;
      reset = 1'b0;
   endtask

   task automatic test_store_load();
      do_store(32'h60, 32'hDEADBEEF);
      do_load(32'h60, 32'hDEADBEEF, 3);
      go_idle();
      @(negedge clk);
      checks++;
      if (rdata !== 32'hDEADBEEF || rdata_valid !== 1'b0) begin
         failures++;
         $display("FAIL rdata_hold: rdata=%h valid=%b expected deadbeef 0", rdata, rdata_valid);
      end
   endtask

   task automatic test_back_to_back();
      do_store(32'h04, 32'h11);
      do_store(32'h08, 32'h22);
      do_load(32'h04, 32'h11, 3);
      do_load(32'h08, 32'h22, 3);
      do_store(32'h14, 32'h77);
      do_load(32'h14, 32'h77, 3);
      go_idle();
   endtask

   task automatic test_wrap();
      do_store(32'h100, 32'h5A5A5A5A);
      do_load(32'h000, 32'h5A5A5A5A, 3);
      go_idle();
   endtask

   task automatic test_misalign();
      @(posedge clk); #1;
      req_write = 1'b0; req_read = 1'b1; addr = 32'h62;
      exp_q.push_back(32'h0);
      @(negedge clk);
      checks++;
      if (misalign !== 1'b1 || stall !== 1'b0 || rdata_valid !== 1'b1) begin
         failures++;
         $display("FAIL misalign_read: misalign=%b stall=%b valid=%b expected 1 0 1",
                  misalign, stall, rdata_valid);
      end
      @(posedge clk); #1;
      req_read = 1'b0; req_write = 1'b1; addr = 32'h61; wdata = 32'h0BADF00D;
      @(negedge clk);
      checks++;
      if (misalign !== 1'b1 || stall !== 1'b0 || rdata_valid !== 1'b0) begin
         failures++;
         $display("FAIL misalign_write: misalign=%b stall=%b valid=%b expected 1 0 0",
                  misalign, stall, rdata_valid);
      end
      go_idle();
      @(negedge clk);
      checks++;
      if (misalign !== 1'b0) begin
         failures++;
         $display("FAIL misalign_pulse: misalign=%b expected 0 after request", misalign);
      end
      do_load(32'h60, 32'hDEADBEEF, 3);
      go_idle();
   endtask

   task automatic test_reset_mid_load();
      do_store(32'h0C, 32'h33);
      @(posedge clk); #1;
      req_write = 1'b0; req_read = 1'b1; addr = 32'h0C;
      @(posedge clk); #1;
      checks++;
      if (stall !== 1'b1) begin
         failures++;
         $display("FAIL midload_stall: stall=%b expected 1 in second stall cycle", stall);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (stall !== 1'b0 || rdata_valid !== 1'b0) begin
         failures++;
         $display("FAIL midload_reset: stall=%b valid=%b expected 0 0", stall, rdata_valid);
      end
      @(negedge clk);
      req_read = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (stall !== 1'b0 || rdata_valid !== 1'b0) begin
         failures++;
         $display("FAIL midload_after: stall=%b valid=%b expected 0 0", stall, rdata_valid);
      end
      do_load(32'h0C, 32'h33, 3);
      go_idle();
   endtask

   task automatic test_lat1();
      int n;
      bit done;
      n = 0; done = 0;
      @(posedge clk); #1;
      r1_write = 1'b1; r1_addr = 32'h10; r1_wdata = 32'hCAFEF00D;
      @(posedge clk); #1;
      r1_write = 1'b0; r1_read = 1'b1;
      exp1_q.push_back(32'hCAFEF00D);
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge clk);
         if (r1_stall) n++;
         else          done = 1;
      end
      checks++;
      if (!done || n != 2) begin
         failures++;
         $display("FAIL lat1_stall_len: got %0d cycles (done=%0b) expected 2", n, done);
      end
      checks++;
      if (r1_valid !== 1'b1) begin
         failures++;
         $display("FAIL lat1_valid: rdata_valid=%b expected 1", r1_valid);
      end
      @(posedge clk); #1;
      r1_read = 1'b0;
   endtask

   initial begin
      test_reset();
      test_store_load();
      test_back_to_back();
      test_wrap();
      test_misalign();
      test_reset_mid_load();
      test_lat1();
      repeat (4) @(posedge clk);
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0 || exp1_q.size() != 0) begin
         failures++;
         $display("FAIL sb_drain: %0d/%0d loads never returned, expected 0/0",
                  exp_q.size(), exp1_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
